// File: rtl/filt_pkg.sv
// Shared definitions for the FsmLog filter blocks: scheduler state encoding
// and limits on the channel count.
package filt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EVT  = 2'd2
   } state_t;

   localparam int unsigned NCH_MIN = 2;
   localparam int unsigned NCH_MAX = 16;

endpackage

// File: rtl/filt_presc.sv
// Sample prescaler: counts 0..i_div and pulses o_tick for one cycle at the top
// of the count.
module filt_presc #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;
   logic             w_wrap;

   // >= rather than == so a lowered i_div cannot strand the counter above it
   assign w_wrap = (r_cnt >= i_div);
   assign o_tick = w_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/filt_sched.sv
// Time-multiplexed glitch filter: one shared update datapath sweeps NCH inputs
// per sample tick and reports each filtered level change on a valid/ready port.
module filt_sched
   import filt_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CNT_W = 3,
   parameter int DIV_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NCH-1:0]          i,
   input  logic [DIV_W-1:0]        div,
   input  logic [CNT_W-1:0]        on_len,
   input  logic [CNT_W-1:0]        off_len,
   output logic [NCH-1:0]          y,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [$clog2(NCH)-1:0]  evt_ch,
   output logic                    evt_lvl,
   output logic                    overrun,
   output state_t                  o_state
);

   localparam int CH_W = $clog2(NCH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

   logic                 w_tick;
   state_t               r_state;
   logic [CH_W-1:0]      r_ch;
   logic                 r_pend;
   logic                 r_overrun;
   logic [NCH-1:0]       r_y;
   logic [CNT_W-1:0]     r_cnt [NCH];
   logic                 r_evt_valid;
   logic [CH_W-1:0]      r_evt_ch;
   logic                 r_evt_lvl;

   logic                 w_sample;
   logic                 w_cur_y;
   logic [CNT_W-1:0]     w_thr_raw;
   logic [CNT_W-1:0]     w_thr;
   logic [CNT_W:0]       w_inc;
   logic                 w_differ;
   logic                 w_reach;
   logic                 w_last;
   logic                 w_take;

   filt_presc #(
      .DIV_W (DIV_W)
   ) u_presc (
      .clk    (clk),
      .rst    (rst),
      .i_div  (div),
      .o_tick (w_tick)
   );

   // Shared update datapath for the channel currently under the scan pointer
   always_comb begin
      w_sample  = i[r_ch];
      w_cur_y   = r_y[r_ch];
      w_thr_raw = w_cur_y ? off_len : on_len;
      w_thr     = (w_thr_raw == '0) ? CNT_W'(1) : w_thr_raw;
      // one extra bit so a threshold of all-ones cannot wrap the compare
      w_inc     = {1'b0, r_cnt[r_ch]} + (CNT_W + 1)'(1);
      w_differ  = w_sample ^ w_cur_y;
      w_reach   = w_differ && (w_inc >= {1'b0, w_thr});
      w_last    = (r_ch == LAST_CH);
      w_take    = (r_state == IDLE) && r_pend;
   end

   // A tick landing on a still-pending request is dropped and flagged
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend    <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_tick) begin
         if (r_pend) begin
            r_overrun <= 1'b1;
         end
         r_pend <= 1'b1;
      end else if (w_take) begin
         r_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ch        <= '0;
         r_y         <= '0;
         r_evt_valid <= 1'b0;
         r_evt_ch    <= '0;
         r_evt_lvl   <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            r_cnt[k] <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (r_pend) begin
                  r_ch    <= '0;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               if (w_reach) begin
                  r_y[r_ch]   <= w_sample;
                  r_cnt[r_ch] <= '0;
                  r_evt_ch    <= r_ch;
                  r_evt_lvl   <= w_sample;
                  r_evt_valid <= 1'b1;
                  r_state     <= EVT;
               end else begin
                  r_cnt[r_ch] <= w_differ ? w_inc[CNT_W-1:0] : '0;
                  if (w_last) begin
                     r_state <= IDLE;
                  end else begin
                     r_ch <= r_ch + CH_W'(1);
                  end
               end
            end
            EVT: begin
               if (evt_ready) begin
                  r_evt_valid <= 1'b0;
                  if (w_last) begin
                     r_state <= IDLE;
                  end else begin
                     r_ch    <= r_ch + CH_W'(1);
                     r_state <= SCAN;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_evt_valid <= 1'b0;
            end
         endcase
      end
   end

   assign y         = r_y;
   assign evt_valid = r_evt_valid;
   assign evt_ch    = r_evt_ch;
   assign evt_lvl   = r_evt_lvl;
   assign overrun   = r_overrun;
   assign o_state   = r_state;

endmodule

// File: tb/tb_filt_sched.sv
// Directed bench for filt_sched: reset, rise, glitch rejection, back-pressure,
// overrun and threshold extremes, with an event scoreboard.
module tb_filt_sched;
   import filt_pkg::*;

   localparam int NCH   = 4;
   localparam int CNT_W = 3;
   localparam int DIV_W = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NCH-1:0]     pin;
   logic [DIV_W-1:0]   div;
   logic [CNT_W-1:0]   on_len;
   logic [CNT_W-1:0]   off_len;
   logic               ready;
   logic [NCH-1:0]     y;
   logic               evt_valid;
   logic [1:0]         evt_ch;
   logic               evt_lvl;
   logic               overrun;
   state_t             state;

   int checks = 0;
   int errors = 0;

   logic [2:0] got_q[$];
   logic [2:0] exp_q[$];

   filt_sched #(
      .NCH   (NCH),
      .CNT_W (CNT_W),
      .DIV_W (DIV_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i         (pin),
      .div       (div),
      .on_len    (on_len),
      .off_len   (off_len),
      .y         (y),
      .evt_valid (evt_valid),
      .evt_ready (ready),
      .evt_ch    (evt_ch),
      .evt_lvl   (evt_lvl),
      .overrun   (overrun),
      .o_state   (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && evt_valid && ready) begin
         got_q.push_back({evt_ch, evt_lvl});
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input state_t s, input int max_cyc, input string tag);
      int n = 0;
      while (state !== s && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(state), 32'(s));
   endtask

   task automatic wait_valid(input int max_cyc, input string tag);
      int n = 0;
      while (evt_valid !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(evt_valid), 32'd1);
   endtask

   task automatic sweep(input string tag);
      wait_state(SCAN, 40, {tag, " start"});
      wait_state(IDLE, 40, {tag, " end"});
   endtask

   task automatic check_events(input string tag);
      chk({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         chk({tag, " event"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      pin     = '0;
      div     = 8'd3;
      on_len  = 3'd3;
      off_len = 3'd3;
      ready   = 1'b0;

      // reset asserted while an event is stalled
      do_reset();
      pin = 4'b0100;
      wait_state(EVT, 150, "reach evt");
      chk("pre-rst evt_valid", 32'(evt_valid), 32'd1);
      chk("pre-rst evt_ch", 32'(evt_ch), 32'd2);
      chk("pre-rst y", 32'(y), 32'h4);
      rst = 1'b1;
      @(negedge clk);
      chk("rst y", 32'(y), 32'h0);
      chk("rst evt_valid", 32'(evt_valid), 32'd0);
      chk("rst evt_ch", 32'(evt_ch), 32'd0);
      chk("rst evt_lvl", 32'(evt_lvl), 32'd0);
      chk("rst overrun", 32'(overrun), 32'd0);
      chk("rst state", 32'(state), 32'(IDLE));

      // rise on ch2 after three sweeps
      div   = 8'd5;
      ready = 1'b1;
      pin   = '0;
      do_reset();
      pin = 4'b0100;
      sweep("rise s1");
      chk("rise y s1", 32'(y), 32'h0);
      sweep("rise s2");
      chk("rise y s2", 32'(y), 32'h0);
      wait_valid(20, "rise valid");
      chk("rise y with valid", 32'(y), 32'h4);
      chk("rise evt_ch", 32'(evt_ch), 32'd2);
      chk("rise evt_lvl", 32'(evt_lvl), 32'd1);
      exp_q.push_back({2'd2, 1'b1});
      wait_state(IDLE, 40, "rise idle");
      sweep("rise s4");
      chk("rise y s4", 32'(y), 32'h4);
      check_events("rise");

      // glitch rejection: two highs, a low, two highs stay filtered
      pin = '0;
      do_reset();
      pin = 4'b0001;
      sweep("gl s1");
      sweep("gl s2");
      pin = 4'b0000;
      sweep("gl s3");
      pin = 4'b0001;
      sweep("gl s4");
      sweep("gl s5");
      chk("glitch y", 32'(y), 32'h0);
      check_events("glitch");
      sweep("gl s6");
      chk("glitch late rise y", 32'(y), 32'h1);
      exp_q.push_back({2'd0, 1'b1});
      check_events("glitch late");

      // back-pressure: ch1 event held, ch3 waits for acceptance
      on_len  = 3'd1;
      off_len = 3'd1;
      ready   = 1'b0;
      pin     = '0;
      do_reset();
      pin = 4'b1010;
      wait_valid(40, "bp valid");
      chk("bp evt_ch", 32'(evt_ch), 32'd1);
      chk("bp evt_lvl", 32'(evt_lvl), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp hold valid", 32'(evt_valid), 32'd1);
         chk("bp hold ch", 32'(evt_ch), 32'd1);
         chk("bp hold state", 32'(state), 32'(EVT));
         chk("bp hold y", 32'(y), 32'h2);
      end
      ready = 1'b1;
      exp_q.push_back({2'd1, 1'b1});
      exp_q.push_back({2'd3, 1'b1});
      wait_state(IDLE, 40, "bp idle");
      chk("bp y", 32'(y), 32'hA);
      sweep("bp s2");
      chk("bp y after", 32'(y), 32'hA);
      check_events("bp");

      // overrun: ticks faster than a sweep, sticky until reset
      div   = 8'd1;
      ready = 1'b0;
      pin   = '0;
      do_reset();
      pin = 4'b0001;
      chk("ovr after rst", 32'(overrun), 32'd0);
      repeat (20) @(negedge clk);
      chk("ovr raised", 32'(overrun), 32'd1);
      ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("ovr sticky", 32'(overrun), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("ovr cleared", 32'(overrun), 32'd0);

      // on_len=0 behaves as 1, with exact tick-to-visit latency
      div     = 8'd5;
      on_len  = 3'd0;
      off_len = 3'd7;
      ready   = 1'b1;
      pin     = 4'b0001;
      do_reset();
      repeat (6) @(negedge clk);
      chk("t0 idle before", 32'(state), 32'(IDLE));
      @(negedge clk);
      chk("t0 scan entry", 32'(state), 32'(SCAN));
      chk("t0 y before", 32'(y), 32'h0);
      @(negedge clk);
      chk("t0 y after visit", 32'(y), 32'h1);
      chk("t0 valid", 32'(evt_valid), 32'd1);
      chk("t0 evt_ch", 32'(evt_ch), 32'd0);
      exp_q.push_back({2'd0, 1'b1});
      wait_state(IDLE, 40, "t0 idle");
      check_events("on0");

      // off_len=7: drop after exactly seven zero sweeps
      pin = 4'b0000;
      for (int k = 1; k <= 6; k++) begin
         sweep("off7");
         chk("off7 hold y", 32'(y), 32'h1);
      end
      sweep("off7 s7");
      chk("off7 drop y", 32'(y), 32'h0);
      exp_q.push_back({2'd0, 1'b0});
      check_events("off7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
